led_rotate_ctrl: RTL and testbench

Control stage that drives the `en` and `dir` inputs of the 16-bit LED rotator. It sits directly upstream of the rotator in the same `my_clk` domain. It conditions two raw pushbuttons and one slide switch by synchronizing, debouncing and one-pulsing them. A small FSM then produces run/stop, manual direction and an automatic "bounce" mode that reverses direction every SPAN steps.

---
 rtl/led_rotate_ctrl.sv | 116 +++++++++++
 tb/tb_led_rotate_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_rotate_ctrl.sv
// Run/stop and direction control for the 16-bit LED rotator.
// Inputs are synchronized, debounced and one-pulsed, then drive a STOP/RUN/BOUNCE FSM.
module led_rotate_ctrl #(
  parameter int unsigned DEB_LEN = 4,
  parameter int unsigned SPAN    = 15
) (
  input  logic       my_clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       sw_bounce,
  output logic       en,
  output logic       dir,
  output logic [1:0] state,
  output logic [3:0] step_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPAN - 1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BOUNCE = 2'b10
  } state_t;

  state_t cur, nxt;

  logic               run_s1, run_s2, dbtn_s1, dbtn_s2, sw_s1, sw_s2;
  logic [DEB_LEN-1:0] run_sh, dbtn_sh;
  logic               run_deb, run_deb_d, dbtn_deb, dbtn_deb_d;
  logic               run_pulse, dir_pulse;
  logic               en_nxt, dir_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Input conditioning: 2-FF sync, shift-register debounce, edge delay for one-pulse
  always_ff @(posedge my_clk or posedge rst) begin
    if (rst) begin
      run_s1     <= 1'b0;
      run_s2     <= 1'b0;
      dbtn_s1    <= 1'b0;
      dbtn_s2    <= 1'b0;
      sw_s1      <= 1'b0;
      sw_s2      <= 1'b0;
      run_sh     <= '0;
      dbtn_sh    <= '0;
      run_deb    <= 1'b0;
      run_deb_d  <= 1'b0;
      dbtn_deb   <= 1'b0;
      dbtn_deb_d <= 1'b0;
    end else begin
      run_s1     <= btn_run;
      run_s2     <= run_s1;
      dbtn_s1    <= btn_dir;
      dbtn_s2    <= dbtn_s1;
      sw_s1      <= sw_bounce;
      sw_s2      <= sw_s1;
      run_sh     <= (run_sh << 1) | DEB_LEN'(run_s2);
      dbtn_sh    <= (dbtn_sh << 1) | DEB_LEN'(dbtn_s2);
      if (&run_sh)       run_deb <= 1'b1;
      else if (~|run_sh) run_deb <= 1'b0;
      if (&dbtn_sh)       dbtn_deb <= 1'b1;
      else if (~|dbtn_sh) dbtn_deb <= 1'b0;
      run_deb_d  <= run_deb;
      dbtn_deb_d <= dbtn_deb;
    end
  end

  assign run_pulse = run_deb & ~run_deb_d;
  assign dir_pulse = dbtn_deb & ~dbtn_deb_d;

  // State and registered outputs
  always_ff @(posedge my_clk or posedge rst) begin
    if (rst) begin
      cur      <= ST_STOP;
      en       <= 1'b0;
      dir      <= 1'b0;
      step_cnt <= '0;
    end else begin
      cur      <= nxt;
      en       <= en_nxt;
      dir      <= dir_nxt;
      step_cnt <= cnt_nxt;
    end
  end

  // Next state; run_pulse wins over the switch
  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_STOP:   if (run_pulse) nxt = sw_s2 ? ST_BOUNCE : ST_RUN;
      ST_RUN:    if (run_pulse) nxt = ST_STOP;
                 else if (sw_s2) nxt = ST_BOUNCE;
      ST_BOUNCE: if (run_pulse) nxt = ST_STOP;
                 else if (!sw_s2) nxt = ST_RUN;
      default:   nxt = ST_STOP;
    endcase
  end

  // Output next values, evaluated under the current (old) state
  always_comb begin
    en_nxt  = (nxt != ST_STOP);
    dir_nxt = dir;
    cnt_nxt = '0;
    if (cur == ST_BOUNCE) begin
      if (step_cnt == CNT_MAX) dir_nxt = ~dir;
      else                     cnt_nxt = CNT_W'(step_cnt + 4'd1);
    end else if (dir_pulse) begin
      dir_nxt = ~dir;
    end
    if (nxt != ST_BOUNCE) cnt_nxt = '0;
  end

  assign state = cur;

endmodule

// File: tb/tb_led_rotate_ctrl.sv
// Directed bench for led_rotate_ctrl: phase table plus hand-written multi-cycle sequences.
module tb_led_rotate_ctrl;

  logic       my_clk, rst, btn_run, btn_dir, sw_bounce;
  logic       en, dir;
  logic [1:0] state;
  logic [3:0] step_cnt;
  logic [15:0] led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       run;
    logic       dbtn;
    logic       sw;
    int         ncyc;
    logic [1:0] st;
    logic       en;
    logic       dir;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [17];

  led_rotate_ctrl #(.DEB_LEN(4), .SPAN(15)) dut (
    .my_clk    (my_clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_dir   (btn_dir),
    .sw_bounce (sw_bounce),
    .en        (en),
    .dir       (dir),
    .state     (state),
    .step_cnt  (step_cnt)
  );

  initial begin
    my_clk = 1'b0;
    forever #5 my_clk = ~my_clk;
  end

  // Downstream rotator model, reset to bit15
  always @(posedge my_clk or posedge rst) begin
    if (rst)     led <= 16'h8000;
    else if (en) led <= dir ? {led[14:0], led[15]} : {led[0], led[15:1]};
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge my_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic set_vec(input int i, input logic r, input logic d, input logic s, input int n,
                         input logic [1:0] st, input logic e, input logic dr, input logic [3:0] c);
    tbl[i] = '{r, d, s, n, st, e, dr, c};
  endtask

  initial begin
    int ecnt;
    logic edir;
    int m;
    int pos;

    set_vec(0,  1'b1, 1'b0, 1'b0, 20, 2'b01, 1'b1, 1'b0, 4'd0);
    set_vec(1,  1'b0, 1'b0, 1'b0, 20, 2'b01, 1'b1, 1'b0, 4'd0);
    set_vec(2,  1'b0, 1'b1, 1'b0, 10, 2'b01, 1'b1, 1'b1, 4'd0);
    set_vec(3,  1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b1, 1'b1, 4'd0);
    set_vec(4,  1'b0, 1'b1, 1'b0, 10, 2'b01, 1'b1, 1'b0, 4'd0);
    set_vec(5,  1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b1, 1'b0, 4'd0);
    set_vec(6,  1'b1, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b0, 4'd0);
    set_vec(7,  1'b0, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b0, 4'd0);
    set_vec(8,  1'b0, 1'b1, 1'b0, 20, 2'b00, 1'b0, 1'b1, 4'd0);
    set_vec(9,  1'b0, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b1, 4'd0);
    set_vec(10, 1'b0, 1'b0, 1'b1, 20, 2'b00, 1'b0, 1'b1, 4'd0);
    set_vec(11, 1'b0, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b1, 4'd0);
    set_vec(12, 1'b1, 1'b0, 1'b0, 20, 2'b01, 1'b1, 1'b1, 4'd0);
    set_vec(13, 1'b0, 1'b0, 1'b1, 10, 2'b10, 1'b1, 1'b1, 4'd7);
    set_vec(14, 1'b0, 1'b0, 1'b0, 3,  2'b01, 1'b1, 1'b1, 4'd0);
    set_vec(15, 1'b1, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b1, 4'd0);
    set_vec(16, 1'b0, 1'b0, 1'b0, 20, 2'b00, 1'b0, 1'b1, 4'd0);

    rst = 1'b1; btn_run = 1'b0; btn_dir = 1'b0; sw_bounce = 1'b0;
    #12;
    check("reset_state", 16'(state), 16'd0);
    check("reset_en", 16'(en), 16'd0);
    check("reset_dir", 16'(dir), 16'd0);
    check("reset_cnt", 16'(step_cnt), 16'd0);
    rst = 1'b0;
    tick(1);

    // Phase table: apply inputs, wait, compare
    for (int i = 0; i < 17; i++) begin
      btn_run = tbl[i].run; btn_dir = tbl[i].dbtn; sw_bounce = tbl[i].sw;
      tick(tbl[i].ncyc);
      check($sformatf("vec%0d_state", i), 16'(state), 16'(tbl[i].st));
      check($sformatf("vec%0d_en", i), 16'(en), 16'(tbl[i].en));
      check($sformatf("vec%0d_dir", i), 16'(dir), 16'(tbl[i].dir));
      check($sformatf("vec%0d_cnt", i), 16'(step_cnt), 16'(tbl[i].cnt));
    end

    // Glitchy button then stable press: single transition on edge 8
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_run = (i % 2 == 0);
      tick(1);
      check($sformatf("glitch%0d_state", i), 16'(state), 16'd0);
    end
    btn_run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("latency_edge%0d_en", k), 16'(en), (k == 8) ? 16'd1 : 16'd0);
    end
    tick(12);
    check("held_state", 16'(state), 16'd1);
    btn_run = 1'b0;
    tick(20);
    check("release_state", 16'(state), 16'd1);

    // Bounce sweep from reset position with rotator model
    do_reset();
    sw_bounce = 1'b1;
    btn_run = 1'b1;
    tick(7);
    check("bounce_pre_state", 16'(state), 16'd0);
    tick(1);
    check("bounce_entry_state", 16'(state), 16'd2);
    check("bounce_entry_led", led, 16'h8000);
    ecnt = 0;
    edir = 1'b0;
    check("bounce_entry_dir", 16'(dir), 16'(edir));
    for (int k = 1; k <= 45; k++) begin
      if (k == 20) btn_dir = 1'b1;
      if (k == 32) btn_dir = 1'b0;
      tick(1);
      if (ecnt == 14) begin
        ecnt = 0;
        edir = ~edir;
      end else begin
        ecnt = ecnt + 1;
      end
      m   = k % 30;
      pos = (m <= 15) ? (15 - m) : (m - 15);
      check($sformatf("sweep%0d_dir", k), 16'(dir), 16'(edir));
      check($sformatf("sweep%0d_cnt", k), 16'(step_cnt), 16'(ecnt));
      check($sformatf("sweep%0d_led", k), led, 16'd1 << pos);
    end

    // In BOUNCE: switch drop and run_pulse land on the same edge -> STOP
    btn_run = 1'b0;
    tick(20);
    check("prio_pre_state", 16'(state), 16'd2);
    btn_run = 1'b1;
    tick(5);
    sw_bounce = 1'b0;
    tick(2);
    check("prio_edge7_state", 16'(state), 16'd2);
    tick(1);
    check("prio_edge8_state", 16'(state), 16'd0);
    check("prio_edge8_en", 16'(en), 16'd0);
    btn_run = 1'b0;
    tick(20);

    // In RUN: run_pulse and dir_pulse together -> STOP with dir toggled
    do_reset();
    btn_run = 1'b1;
    tick(20);
    check("simul_pre_state", 16'(state), 16'd1);
    btn_run = 1'b0;
    tick(20);
    btn_run = 1'b1;
    btn_dir = 1'b1;
    tick(7);
    check("simul_edge7_state", 16'(state), 16'd1);
    check("simul_edge7_dir", 16'(dir), 16'd0);
    tick(1);
    check("simul_edge8_state", 16'(state), 16'd0);
    check("simul_edge8_dir", 16'(dir), 16'd1);
    check("simul_edge8_en", 16'(en), 16'd0);
    btn_run = 1'b0;
    btn_dir = 1'b0;
    tick(20);

    // Asynchronous reset mid-RUN with dir=1
    btn_run = 1'b1;
    tick(20);
    check("async_pre_state", 16'(state), 16'd1);
    check("async_pre_dir", 16'(dir), 16'd1);
    btn_run = 1'b0;
    tick(20);
    #3 rst = 1'b1;
    #1;
    check("async_state", 16'(state), 16'd0);
    check("async_en", 16'(en), 16'd0);
    check("async_dir", 16'(dir), 16'd0);
    check("async_cnt", 16'(step_cnt), 16'd0);
    rst = 1'b0;
    tick(3);
    check("post_reset_state", 16'(state), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
